// File: rtl/reg_control_file_if.sv
// Control bundle from the CPU sequencer to the register block: select, write,
// bus-drive, exchange and switch #4 controls.
interface reg_control_file_if;
    logic [1:0] ctl_reg_gp_sel;
    logic [1:0] ctl_reg_gp_hilo;
    logic       ctl_reg_gp_we;
    logic [1:0] ctl_reg_sys_hilo;
    logic       ctl_reg_sys_we_lo;
    logic       ctl_reg_sys_we_hi;
    logic       ctl_reg_sys_we;
    logic       ctl_reg_sel_pc;
    logic       ctl_reg_sel_ir;
    logic       ctl_reg_sel_wz;
    logic       ctl_reg_not_pc;
    logic       ctl_reg_use_sp;
    logic       use_ixiy;
    logic       use_ix;
    logic       ctl_reg_exx;
    logic       ctl_reg_ex_af;
    logic       ctl_reg_ex_de_hl;
    logic       hold_clk_wait;
    logic       ctl_reg_in_hi;
    logic       ctl_reg_in_lo;
    logic       ctl_reg_out_hi;
    logic       ctl_reg_out_lo;
    logic       ctl_sw_4d;
    logic       ctl_sw_4u;

    modport master (
        output ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we, ctl_reg_sys_hilo,
               ctl_reg_sys_we_lo, ctl_reg_sys_we_hi, ctl_reg_sys_we,
               ctl_reg_sel_pc, ctl_reg_sel_ir, ctl_reg_sel_wz, ctl_reg_not_pc,
               ctl_reg_use_sp, use_ixiy, use_ix, ctl_reg_exx, ctl_reg_ex_af,
               ctl_reg_ex_de_hl, hold_clk_wait, ctl_reg_in_hi, ctl_reg_in_lo,
               ctl_reg_out_hi, ctl_reg_out_lo, ctl_sw_4d, ctl_sw_4u
    );

    modport slave (
        input  ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we, ctl_reg_sys_hilo,
               ctl_reg_sys_we_lo, ctl_reg_sys_we_hi, ctl_reg_sys_we,
               ctl_reg_sel_pc, ctl_reg_sel_ir, ctl_reg_sel_wz, ctl_reg_not_pc,
               ctl_reg_use_sp, use_ixiy, use_ix, ctl_reg_exx, ctl_reg_ex_af,
               ctl_reg_ex_de_hl, hold_clk_wait, ctl_reg_in_hi, ctl_reg_in_lo,
               ctl_reg_out_hi, ctl_reg_out_lo, ctl_sw_4d, ctl_sw_4u
    );
endinterface

// File: rtl/reg_control_file.sv
// Z80-style register block: select decode, primary/alternate register banks,
// system registers, bidirectional data/address-side bus ports and switch #4.
module reg_control_file (
    input  logic              clk,
    input  logic              nreset,
    reg_control_file_if.slave ctl,
    inout  wire  [7:0]        db_hi_ds,
    inout  wire  [7:0]        db_lo_ds,
    inout  wire  [7:0]        db_hi_as,
    inout  wire  [7:0]        db_lo_as
);
    logic        bank_main;
    logic        bank_af;
    logic [1:0]  swap_dehl;

    logic [15:0] af [2];
    logic [15:0] bc [2];
    logic [15:0] de [2];
    logic [15:0] hl [2];
    logic [15:0] pc, ir, wz, ix, iy, sp;

    logic        sel_pc, sel_wz, sel_ir, sel_ix, sel_iy, sel_sp;
    logic        explicit_sys, red_hl, redirect, sys_any;
    logic [1:0]  gp_phys;
    logic [15:0] gp_rd, sys_rd;
    logic [1:0]  sel_gp, sel_sys, in_en, out_en, sys_we_any;
    logic [1:0]  gp_wr, sys_wr, gp_drv, sys_drv, sw_dn;
    logic        sw_up;
    logic [15:0] gp_din, sys_din;

    assign gp_din  = {db_hi_ds, db_lo_ds};
    assign sys_din = {db_hi_as, db_lo_as};

    always_comb begin
        sel_pc       = ctl.ctl_reg_sel_pc & ~ctl.ctl_reg_not_pc;
        sel_wz       = ~sel_pc & ctl.ctl_reg_sel_wz;
        sel_ir       = ~sel_pc & ~sel_wz & ctl.ctl_reg_sel_ir;
        explicit_sys = sel_pc | sel_wz | sel_ir;
        red_hl       = ~explicit_sys & (ctl.ctl_reg_gp_sel == 2'b11) & ctl.use_ixiy;
        sel_ix       = red_hl & ctl.use_ix;
        sel_iy       = red_hl & ~ctl.use_ix;
        sel_sp       = ~explicit_sys & (ctl.ctl_reg_gp_sel == 2'b00) & ctl.ctl_reg_use_sp;
        redirect     = red_hl | sel_sp;
        sys_any      = explicit_sys | redirect;

        sel_gp     = ctl.ctl_reg_gp_hilo & {2{~redirect}};
        sel_sys    = ctl.ctl_reg_sys_hilo | ({2{redirect}} & ctl.ctl_reg_gp_hilo);
        in_en      = {ctl.ctl_reg_in_hi, ctl.ctl_reg_in_lo};
        out_en     = {ctl.ctl_reg_out_hi, ctl.ctl_reg_out_lo};
        sys_we_any = {ctl.ctl_reg_sys_we_hi, ctl.ctl_reg_sys_we_lo}
                   | {2{ctl.ctl_reg_sys_we | (redirect & ctl.ctl_reg_gp_we)}};

        gp_wr  = in_en & sel_gp & {2{ctl.ctl_reg_gp_we}};
        sys_wr = in_en & sel_sys & sys_we_any & {2{sys_any}};
    end

    // DE/HL exchange is a remap of the pair index rather than a data move.
    always_comb begin
        gp_phys = ctl.ctl_reg_gp_sel;
        if (swap_dehl[bank_main] && ctl.ctl_reg_gp_sel[1])
            gp_phys = {1'b1, ~ctl.ctl_reg_gp_sel[0]};
        unique case (gp_phys)
            2'b00:   gp_rd = af[bank_af];
            2'b01:   gp_rd = bc[bank_main];
            2'b10:   gp_rd = de[bank_main];
            default: gp_rd = hl[bank_main];
        endcase
    end

    always_comb begin
        sys_rd = '0;
        if (sel_pc)      sys_rd = pc;
        else if (sel_wz) sys_rd = wz;
        else if (sel_ir) sys_rd = ir;
        else if (sel_ix) sys_rd = ix;
        else if (sel_iy) sys_rd = iy;
        else if (sel_sp) sys_rd = sp;
    end

    function automatic logic [15:0] merge(input logic [15:0] old_val,
                                          input logic [15:0] new_val,
                                          input logic [1:0]  be);
        merge = {be[1] ? new_val[15:8] : old_val[15:8],
                 be[0] ? new_val[7:0]  : old_val[7:0]};
    endfunction

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bank_main <= 1'b0;
            bank_af   <= 1'b0;
            swap_dehl <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                af[i] <= '1;
                bc[i] <= '0;
                de[i] <= '0;
                hl[i] <= '0;
            end
            pc <= '0;
            ir <= '0;
            wz <= '0;
            ix <= '0;
            iy <= '0;
            sp <= '1;
        end else if (!ctl.hold_clk_wait) begin
            if (ctl.ctl_reg_exx)      bank_main <= ~bank_main;
            if (ctl.ctl_reg_ex_af)    bank_af   <= ~bank_af;
            if (ctl.ctl_reg_ex_de_hl) swap_dehl[bank_main] <= ~swap_dehl[bank_main];

            if (|gp_wr) begin
                unique case (gp_phys)
                    2'b00:   af[bank_af]   <= merge(af[bank_af],   gp_din, gp_wr);
                    2'b01:   bc[bank_main] <= merge(bc[bank_main], gp_din, gp_wr);
                    2'b10:   de[bank_main] <= merge(de[bank_main], gp_din, gp_wr);
                    default: hl[bank_main] <= merge(hl[bank_main], gp_din, gp_wr);
                endcase
            end

            if (|sys_wr) begin
                if (sel_pc)      pc <= merge(pc, sys_din, sys_wr);
                else if (sel_wz) wz <= merge(wz, sys_din, sys_wr);
                else if (sel_ir) ir <= merge(ir, sys_din, sys_wr);
                else if (sel_ix) ix <= merge(ix, sys_din, sys_wr);
                else if (sel_iy) iy <= merge(iy, sys_din, sys_wr);
                else if (sel_sp) sp <= merge(sp, sys_din, sys_wr);
            end
        end
    end

    // A byte being written is never driven back; reset releases every driver.
    always_comb begin
        gp_drv  = out_en & sel_gp & ~gp_wr & {2{nreset}};
        sys_drv = out_en & sel_sys & ~sys_wr & {2{sys_any & nreset}};
        sw_dn   = {2{ctl.ctl_sw_4d & nreset}} & ctl.ctl_reg_sys_hilo;
        sw_up   = ctl.ctl_sw_4u & ~ctl.ctl_sw_4d & nreset;
    end

    assign db_hi_ds = gp_drv[1]  ? gp_rd[15:8]  : (sw_up    ? db_hi_as : 8'bz);
    assign db_lo_ds = gp_drv[0]  ? gp_rd[7:0]   : (sw_up    ? db_lo_as : 8'bz);
    assign db_hi_as = sys_drv[1] ? sys_rd[15:8] : (sw_dn[1] ? db_hi_ds : 8'bz);
    assign db_lo_as = sys_drv[0] ? sys_rd[7:0]  : (sw_dn[0] ? db_lo_ds : 8'bz);
endmodule

// File: tb/tb_reg_control_file.sv
// Directed bench for reg_control_file: GP/system writes and reads, exchanges,
// redirects, hold, byte writes and asynchronous reset.
module tb_reg_control_file;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] ds_val = '0;
    logic [15:0] as_val = '0;
    logic        ds_en = 1'b0;
    logic        as_en = 1'b0;
    logic [15:0] rd;

    wire [7:0] db_hi_ds, db_lo_ds, db_hi_as, db_lo_as;

    assign db_hi_ds = ds_en ? ds_val[15:8] : 8'bz;
    assign db_lo_ds = ds_en ? ds_val[7:0]  : 8'bz;
    assign db_hi_as = as_en ? as_val[15:8] : 8'bz;
    assign db_lo_as = as_en ? as_val[7:0]  : 8'bz;

    reg_control_file_if ctl_if ();

    reg_control_file dut (
        .clk      (clk),
        .nreset   (nreset),
        .ctl      (ctl_if.slave),
        .db_hi_ds (db_hi_ds),
        .db_lo_ds (db_lo_ds),
        .db_hi_as (db_hi_as),
        .db_lo_as (db_lo_as)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ctl_if.ctl_reg_gp_sel    = 2'b00;
        ctl_if.ctl_reg_gp_hilo   = 2'b00;
        ctl_if.ctl_reg_gp_we     = 1'b0;
        ctl_if.ctl_reg_sys_hilo  = 2'b00;
        ctl_if.ctl_reg_sys_we_lo = 1'b0;
        ctl_if.ctl_reg_sys_we_hi = 1'b0;
        ctl_if.ctl_reg_sys_we    = 1'b0;
        ctl_if.ctl_reg_sel_pc    = 1'b0;
        ctl_if.ctl_reg_sel_ir    = 1'b0;
        ctl_if.ctl_reg_sel_wz    = 1'b0;
        ctl_if.ctl_reg_not_pc    = 1'b0;
        ctl_if.ctl_reg_use_sp    = 1'b0;
        ctl_if.use_ixiy          = 1'b0;
        ctl_if.use_ix            = 1'b0;
        ctl_if.ctl_reg_exx       = 1'b0;
        ctl_if.ctl_reg_ex_af     = 1'b0;
        ctl_if.ctl_reg_ex_de_hl  = 1'b0;
        ctl_if.hold_clk_wait     = 1'b0;
        ctl_if.ctl_reg_in_hi     = 1'b0;
        ctl_if.ctl_reg_in_lo     = 1'b0;
        ctl_if.ctl_reg_out_hi    = 1'b0;
        ctl_if.ctl_reg_out_lo    = 1'b0;
        ctl_if.ctl_sw_4d         = 1'b0;
        ctl_if.ctl_sw_4u         = 1'b0;
        ds_en = 1'b0;
        as_en = 1'b0;
    endtask

    task automatic gp_write(input logic [1:0] sel, input logic [1:0] hilo,
                            input logic [15:0] val, input logic hold);
        @(negedge clk);
        idle();
        ctl_if.ctl_reg_gp_sel  = sel;
        ctl_if.ctl_reg_gp_hilo = hilo;
        ctl_if.ctl_reg_gp_we   = 1'b1;
        ctl_if.ctl_reg_in_hi   = 1'b1;
        ctl_if.ctl_reg_in_lo   = 1'b1;
        ctl_if.hold_clk_wait   = hold;
        ds_val = val;
        ds_en  = 1'b1;
        @(negedge clk);
        idle();
    endtask

    task automatic gp_read(input logic [1:0] sel, output logic [15:0] val);
        @(negedge clk);
        idle();
        ctl_if.ctl_reg_gp_sel  = sel;
        ctl_if.ctl_reg_gp_hilo = 2'b11;
        ctl_if.ctl_reg_out_hi  = 1'b1;
        ctl_if.ctl_reg_out_lo  = 1'b1;
        #2 val = {db_hi_ds, db_lo_ds};
    endtask

    // which: 0 = PC, 1 = WZ, 2 = IR
    task automatic sel_sys(input int which);
        ctl_if.ctl_reg_sel_pc = (which == 0);
        ctl_if.ctl_reg_sel_wz = (which == 1);
        ctl_if.ctl_reg_sel_ir = (which == 2);
    endtask

    task automatic sys_write_sw(input int which, input logic [15:0] val);
        @(negedge clk);
        idle();
        sel_sys(which);
        ctl_if.ctl_reg_sys_hilo  = 2'b11;
        ctl_if.ctl_reg_sys_we_hi = 1'b1;
        ctl_if.ctl_reg_sys_we_lo = 1'b1;
        ctl_if.ctl_reg_in_hi     = 1'b1;
        ctl_if.ctl_reg_in_lo     = 1'b1;
        ctl_if.ctl_sw_4d         = 1'b1;
        ds_val = val;
        ds_en  = 1'b1;
        @(negedge clk);
        idle();
    endtask

    task automatic sys_read_sw(input int which, output logic [15:0] val);
        @(negedge clk);
        idle();
        sel_sys(which);
        ctl_if.ctl_reg_sys_hilo = 2'b11;
        ctl_if.ctl_reg_out_hi   = 1'b1;
        ctl_if.ctl_reg_out_lo   = 1'b1;
        ctl_if.ctl_sw_4u        = 1'b1;
        #2 val = {db_hi_ds, db_lo_ds};
    endtask

    task automatic toggle(input logic exx, input logic ex_af, input logic ex_de_hl,
                          input logic hold);
        @(negedge clk);
        idle();
        ctl_if.ctl_reg_exx      = exx;
        ctl_if.ctl_reg_ex_af    = ex_af;
        ctl_if.ctl_reg_ex_de_hl = ex_de_hl;
        ctl_if.hold_clk_wait    = hold;
        @(negedge clk);
        idle();
    endtask

    task automatic ixiy_write(input logic ix_sel, input logic [15:0] val);
        @(negedge clk);
        idle();
        ctl_if.use_ixiy        = 1'b1;
        ctl_if.use_ix          = ix_sel;
        ctl_if.ctl_reg_gp_sel  = 2'b11;
        ctl_if.ctl_reg_gp_hilo = 2'b11;
        ctl_if.ctl_reg_gp_we   = 1'b1;
        ctl_if.ctl_reg_in_hi   = 1'b1;
        ctl_if.ctl_reg_in_lo   = 1'b1;
        as_val = val;
        as_en  = 1'b1;
        @(negedge clk);
        idle();
    endtask

    task automatic redirect_read(input logic [1:0] sel, input logic ixiy, input logic ix_sel,
                                 input logic sp_sel, output logic [15:0] val);
        @(negedge clk);
        idle();
        ctl_if.use_ixiy        = ixiy;
        ctl_if.use_ix          = ix_sel;
        ctl_if.ctl_reg_use_sp  = sp_sel;
        ctl_if.ctl_reg_gp_sel  = sel;
        ctl_if.ctl_reg_gp_hilo = 2'b11;
        ctl_if.ctl_reg_out_hi  = 1'b1;
        ctl_if.ctl_reg_out_lo  = 1'b1;
        #2 val = {db_hi_as, db_lo_as};
    endtask

    // Drives an explicit system selection straight onto the address side.
    task automatic sys_read_as(input logic pc_s, input logic not_pc, input logic wz_s,
                               input logic bg_en, output logic [15:0] val);
        @(negedge clk);
        idle();
        ctl_if.ctl_reg_sel_pc   = pc_s;
        ctl_if.ctl_reg_not_pc   = not_pc;
        ctl_if.ctl_reg_sel_wz   = wz_s;
        ctl_if.ctl_reg_sys_hilo = 2'b11;
        ctl_if.ctl_reg_out_hi   = 1'b1;
        ctl_if.ctl_reg_out_lo   = 1'b1;
        as_val = 16'h0000;
        as_en  = bg_en;
        #2 val = {db_hi_as, db_lo_as};
    endtask

    initial begin
        idle();
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        gp_read(2'b00, rd); check("reset_af", rd, 16'hFFFF);
        gp_read(2'b01, rd); check("reset_bc", rd, 16'h0000);
        gp_read(2'b10, rd); check("reset_de", rd, 16'h0000);
        gp_read(2'b11, rd); check("reset_hl", rd, 16'h0000);
        redirect_read(2'b00, 1'b0, 1'b0, 1'b1, rd); check("reset_sp", rd, 16'hFFFF);

        sys_write_sw(1, 16'h8141);
        sys_write_sw(0, 16'h8242);
        sys_write_sw(2, 16'h8343);
        sys_read_sw(1, rd); check("wz_rd", rd, 16'h8141);
        sys_read_sw(0, rd); check("pc_rd", rd, 16'h8242);
        sys_read_sw(2, rd); check("ir_rd", rd, 16'h8343);

        gp_write(2'b00, 2'b11, 16'hAA55, 1'b0);
        gp_write(2'b01, 2'b11, 16'hAB56, 1'b0);
        gp_write(2'b10, 2'b11, 16'hAC57, 1'b0);
        gp_write(2'b11, 2'b11, 16'hAD58, 1'b0);
        gp_read(2'b00, rd); check("af_rd", rd, 16'hAA55);
        gp_read(2'b01, rd); check("bc_rd", rd, 16'hAB56);
        gp_read(2'b10, rd); check("de_rd", rd, 16'hAC57);
        gp_read(2'b11, rd); check("hl_rd", rd, 16'hAD58);

        toggle(1'b1, 1'b0, 1'b0, 1'b0);
        gp_read(2'b01, rd); check("exx_bc_alt", rd, 16'h0000);
        toggle(1'b1, 1'b0, 1'b0, 1'b0);
        gp_read(2'b01, rd); check("exx_bc_main", rd, 16'hAB56);
        toggle(1'b0, 1'b0, 1'b1, 1'b0);
        gp_read(2'b10, rd); check("exdehl_de", rd, 16'hAD58);
        gp_read(2'b11, rd); check("exdehl_hl", rd, 16'hAC57);
        toggle(1'b0, 1'b1, 1'b0, 1'b0);
        gp_read(2'b00, rd); check("exaf_alt", rd, 16'hFFFF);
        toggle(1'b0, 1'b1, 1'b1, 1'b0);
        gp_read(2'b10, rd); check("restore_de", rd, 16'hAC57);
        gp_read(2'b00, rd); check("restore_af", rd, 16'hAA55);
        toggle(1'b1, 1'b1, 1'b0, 1'b0);
        gp_read(2'b00, rd); check("both_af", rd, 16'hFFFF);
        gp_read(2'b01, rd); check("both_bc", rd, 16'h0000);
        toggle(1'b1, 1'b1, 1'b0, 1'b0);
        gp_read(2'b00, rd); check("both_back_af", rd, 16'hAA55);

        ixiy_write(1'b1, 16'h1234);
        ixiy_write(1'b0, 16'h5678);
        redirect_read(2'b11, 1'b1, 1'b1, 1'b0, rd); check("ix_rd", rd, 16'h1234);
        redirect_read(2'b11, 1'b1, 1'b0, 1'b0, rd); check("iy_rd", rd, 16'h5678);
        gp_read(2'b11, rd); check("hl_kept", rd, 16'hAD58);

        sys_read_as(1'b1, 1'b1, 1'b0, 1'b1, rd); check("not_pc_nodrive", rd, 16'h0000);
        sys_read_as(1'b1, 1'b1, 1'b1, 1'b0, rd); check("not_pc_wz", rd, 16'h8141);
        sys_read_as(1'b1, 1'b0, 1'b1, 1'b0, rd); check("pc_over_wz", rd, 16'h8242);

        gp_write(2'b01, 2'b11, 16'h1111, 1'b1);
        gp_read(2'b01, rd); check("hold_bc", rd, 16'hAB56);
        gp_write(2'b01, 2'b01, 16'h0099, 1'b0);
        gp_read(2'b01, rd); check("lo_byte_bc", rd, 16'hAB99);
        toggle(1'b1, 1'b0, 1'b0, 1'b1);
        gp_read(2'b01, rd); check("hold_exx", rd, 16'hAB99);

        @(negedge clk);
        idle();
        ctl_if.ctl_reg_gp_sel  = 2'b00;
        ctl_if.ctl_reg_gp_hilo = 2'b11;
        ctl_if.ctl_reg_out_hi  = 1'b1;
        ctl_if.ctl_reg_out_lo  = 1'b1;
        #1 nreset = 1'b0;
        #1 ds_val = 16'h0000;
        ds_en = 1'b1;
        #1 check("reset_release", {db_hi_ds, db_lo_ds}, 16'h0000);
        ds_en = 1'b0;
        @(negedge clk);
        idle();
        nreset = 1'b1;
        gp_read(2'b00, rd); check("rereset_af", rd, 16'hFFFF);
        gp_read(2'b01, rd); check("rereset_bc", rd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
